// File: rtl/audio_level_accumulator.sv
// Windowed mean/peak absolute level of a signed sample stream.
// Two-stage pipeline: |sample| register, then accumulate/peak with a window close strobe.
module audio_level_accumulator #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int LOG2_WINDOW  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic [SAMPLE_WIDTH-1:0] level_data,
  output logic [SAMPLE_WIDTH-1:0] peak_data,
  output logic                    level_ready,
  output logic [LOG2_WINDOW-1:0]  window_count
);
  localparam int ACC_W = SAMPLE_WIDTH + LOG2_WINDOW;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic                    s1_load, acc_en;
  logic                    s1_vld;
  logic [SAMPLE_WIDTH-1:0] s1_abs, abs_val;
  logic [ACC_W-1:0]        acc, sum_next;
  logic [SAMPLE_WIDTH-1:0] peak, peak_next;
  logic                    win_last;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = enable ? RUN : IDLE;
  end

  always_comb begin
    s1_load = 1'b0;
    acc_en  = 1'b0;
    case (state)
      IDLE: s1_load = enable & sample_valid;
      RUN: begin
        s1_load = enable & sample_valid;
        acc_en  = enable & s1_vld;
      end
      default: ;
    endcase
  end

  // Two's-complement negate in the same width maps the most negative code onto its magnitude.
  assign abs_val = sample_data[SAMPLE_WIDTH-1] ? (~sample_data + 1'b1) : sample_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_abs <= '0;
    end else begin
      s1_vld <= s1_load;
      s1_abs <= abs_val;
    end
  end

  assign sum_next  = acc + ACC_W'(s1_abs);
  assign peak_next = (s1_abs > peak) ? s1_abs : peak;
  assign win_last  = (window_count == {LOG2_WINDOW{1'b1}});

  always_ff @(posedge clk) begin
    level_ready <= 1'b0;
    if (!reset_n) begin
      acc          <= '0;
      peak         <= '0;
      window_count <= '0;
      level_data   <= '0;
      peak_data    <= '0;
    end else if (!enable) begin
      // Partial window is dropped; published values stay put.
      acc          <= '0;
      peak         <= '0;
      window_count <= '0;
    end else if (acc_en) begin
      window_count <= window_count + 1'b1;
      if (win_last) begin
        level_data  <= SAMPLE_WIDTH'(sum_next >> LOG2_WINDOW);
        peak_data   <= peak_next;
        level_ready <= 1'b1;
        acc         <= '0;
        peak        <= '0;
      end else begin
        acc  <= sum_next;
        peak <= peak_next;
      end
    end
  end
endmodule

// File: tb/tb_audio_level_accumulator.sv
// Directed bench for audio_level_accumulator with a 4-sample window.
module tb_audio_level_accumulator;
  logic       clk = 1'b0;
  logic       reset_n, enable, sample_valid;
  logic [7:0] sample_data, level_data, peak_data;
  logic       level_ready;
  logic [1:0] window_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0][7:0] s;
    logic [7:0]      lvl;
    logic [7:0]      pk;
  } vec_t;
  vec_t vecs[6];

  audio_level_accumulator #(.SAMPLE_WIDTH(8), .LOG2_WINDOW(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .level_data(level_data), .peak_data(peak_data),
    .level_ready(level_ready), .window_count(window_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; presents one sample for the next rising edge.
  task automatic send(input logic [7:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // After the final send: pulse lands on the following edge and lasts one cycle.
  task automatic expect_close(input string name, input int lvl, input int pk);
    chk({name, " rdy_early"}, level_ready, 0);
    @(negedge clk);
    chk({name, " rdy"}, level_ready, 1);
    chk({name, " level"}, level_data, lvl);
    chk({name, " peak"}, peak_data, pk);
    chk({name, " count"}, window_count, 0);
    @(negedge clk);
    chk({name, " rdy_drop"}, level_ready, 0);
  endtask

  initial begin
    int pulses;
    int first_at;
    logic [7:0] gs[4];

    vecs[0].s = {8'hD8, 8'd30, 8'hEC, 8'd10}; vecs[0].lvl = 8'd25;  vecs[0].pk = 8'd40;
    vecs[1].s = {8'h80, 8'h80, 8'h80, 8'h80}; vecs[1].lvl = 8'h80;  vecs[1].pk = 8'h80;
    vecs[2].s = {8'd1, 8'd1, 8'd1, 8'd1};     vecs[2].lvl = 8'd1;   vecs[2].pk = 8'd1;
    vecs[3].s = {8'd127, 8'd127, 8'd127, 8'd127}; vecs[3].lvl = 8'd127; vecs[3].pk = 8'd127;
    vecs[4].s = {8'd0, 8'd0, 8'd0, 8'd3};     vecs[4].lvl = 8'd0;   vecs[4].pk = 8'd3;
    vecs[5].s = {8'd4, 8'hFD, 8'd2, 8'hFF};   vecs[5].lvl = 8'd2;   vecs[5].pk = 8'd4;

    reset_n = 1'b0; enable = 1'b1; sample_valid = 1'b0; sample_data = 8'd55;
    for (int i = 0; i < 3; i++) begin
      sample_valid = ~sample_valid;
      @(negedge clk);
      chk("reset level", level_data, 0);
      chk("reset peak", peak_data, 0);
      chk("reset rdy", level_ready, 0);
      chk("reset count", window_count, 0);
    end
    sample_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) begin
        send(vecs[v].s[k]);
        if (k < 3) chk($sformatf("vec%0d rdy_mid", v), level_ready, 0);
      end
      expect_close($sformatf("vec%0d", v), vecs[v].lvl, vecs[v].pk);
    end

    // Eight back-to-back ones: two closes exactly four cycles apart.
    pulses = 0; first_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin sample_valid = 1'b1; sample_data = 8'd1; end
      else sample_valid = 1'b0;
      @(negedge clk);
      if (level_ready) begin
        pulses++;
        chk("b2b level", level_data, 1);
        chk("b2b peak", peak_data, 1);
        if (first_at < 0) first_at = i;
        else chk("b2b spacing", i - first_at, 4);
      end
    end
    chk("b2b pulses", pulses, 2);

    // Same window as vec0 with random gaps between valids.
    gs[0] = 8'd10; gs[1] = 8'hEC; gs[2] = 8'd30; gs[3] = 8'hD8;
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap rdy_early", level_ready, 0);
      end
      send(gs[k]);
    end
    expect_close("gap", 25, 40);

    // Enable drop mid-window discards the partial sum and holds outputs.
    send(8'd50);
    send(8'd50);
    enable = 1'b0;
    @(negedge clk);
    chk("idle level hold", level_data, 25);
    chk("idle peak hold", peak_data, 40);
    chk("idle count", window_count, 0);
    chk("idle rdy", level_ready, 0);
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) send(8'd4);
    expect_close("en_drop", 4, 4);

    // Synchronous reset mid-window.
    for (int k = 0; k < 3; k++) send(8'd100);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid reset level", level_data, 0);
    chk("mid reset count", window_count, 0);
    for (int k = 0; k < 4; k++) begin
      send(8'd8);
      if (k < 3) chk("post reset rdy_early", level_ready, 0);
    end
    expect_close("post_reset", 8, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
